// File: rtl/seq_mult_sm_if.sv
// Start/ready/done handshake and operand/result bus for the sequential multiplier.
// The master issues multiplies; the slave (seq_mult_sm) computes them.
interface seq_mult_sm_if #(
    parameter int WA = 8,
    parameter int WB = 8
);
    logic              start;
    logic              signed_mode;
    logic [WA-1:0]     a;
    logic [WB-1:0]     b;
    logic [WA+WB-1:0]  product;
    logic              ready;
    logic              busy;
    logic              done;

    modport master (
        output start, signed_mode, a, b,
        input  product, ready, busy, done
    );

    modport slave (
        input  start, signed_mode, a, b,
        output product, ready, busy, done
    );
endinterface

// File: rtl/seq_mult_sm.sv
// Sequential shift-add multiplier on operand magnitudes, with signed/unsigned mode,
// zero-operand bypass and early exit once the multiplier's last set bit is consumed.
module seq_mult_sm #(
    parameter int WA = 8,
    parameter int WB = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_mult_sm_if.slave  bus
);
    localparam int W = WA + WB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [WB-1:0]   mplier_q, mplier_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    product_q, product_d;

    logic [WA-1:0]   a_mag;
    logic [WB-1:0]   b_mag;
    logic [W-1:0]    acc_next;

    always_comb begin
        state_d   = state_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;

        a_mag    = (bus.signed_mode && bus.a[WA-1]) ? -bus.a : bus.a;
        b_mag    = (bus.signed_mode && bus.b[WB-1]) ? -bus.b : bus.b;
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    neg_d    = bus.signed_mode & (bus.a[WA-1] ^ bus.b[WB-1]);
                    mcand_d  = {{WB{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    if (bus.a == '0 || bus.b == '0) begin
                        product_d = '0;
                        state_d   = DONE;
                    end else begin
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                // Only bit 0 left (or none): this edge consumes the last set bit.
                if (mplier_q[WB-1:1] == '0) begin
                    product_d = neg_q ? -acc_next : acc_next;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            neg_q     <= neg_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign bus.product = product_q;
    assign bus.ready   = (state_q == IDLE);
    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
endmodule

// File: tb/tb_seq_mult_sm.sv
// Directed bench for seq_mult_sm: scoreboarded products, latency, handshake and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_mult_sm;
    localparam int WA = 8;
    localparam int WB = 8;
    localparam int W  = WA + WB;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    seq_mult_sm_if #(.WA(WA), .WB(WB)) bus ();

    seq_mult_sm #(.WA(WA), .WB(WB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [W-1:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                           input logic sm);
        int sa, sb, p;
        sa = sm ? int'($signed(a)) : int'(a);
        sb = sm ? int'($signed(b)) : int'(b);
        p  = sa * sb;
        return W'(p);
    endfunction

    // Edges after the accept edge until done is visible; 0 for the zero bypass.
    function automatic int exp_lat(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                   input logic sm);
        logic [WB-1:0] m;
        int n;
        n = 0;
        if (a == '0 || b == '0) return 0;
        m = (sm && b[WB-1]) ? -b : b;
        for (int i = 0; i < WB; i++) if (m[i]) n = i + 1;
        return n;
    endfunction

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 32'(bus.ready), 32'd1);
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (!bus.done && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [WA-1:0] a, input logic [WB-1:0] b,
                          input logic sm);
        logic [W-1:0] exp;
        int lat, cycles;
        wait_ready();
        bus.a = a; bus.b = b; bus.signed_mode = sm; bus.start = 1'b1;
        sb_q.push_back(model(a, b, sm));
        lat = exp_lat(a, b, sm);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'(lat > 0));
        wait_done(tag, cycles);
        check({tag, "_latency"}, 32'(cycles), 32'(lat));
        exp = sb_q.pop_front();
        check({tag, "_product"}, 32'(bus.product), 32'(exp));
        @(negedge clk);
        check({tag, "_done_width"}, 32'(bus.done), 32'd0);
        check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
        check({tag, "_product_hold"}, 32'(bus.product), 32'(exp));
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    initial begin
        logic [W-1:0] exp;
        logic [2:0]   pat [5];
        int cycles, cnt;

        reset_n = 1'b0;
        bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        check("rst_product", 32'(bus.product), 32'd0);
        check("rst_flags", 32'({bus.ready, bus.busy, bus.done}), 32'(3'b100));
        reset_n = 1'b1;
        @(negedge clk);

        run_op("u13x11",   8'd13,  8'd11,  1'b0);
        run_op("s_m3x5",   8'hFD,  8'd5,   1'b1);
        run_op("u253x5",   8'hFD,  8'd5,   1'b0);
        run_op("s_m128sq", 8'h80,  8'h80,  1'b1);
        run_op("u255sq",   8'hFF,  8'hFF,  1'b0);
        run_op("zero_a",   8'd0,   8'd200, 1'b0);
        run_op("u7x1",     8'd7,   8'd1,   1'b0);
        run_op("s_5xm7",   8'd5,   8'hF9,  1'b1);
        run_op("zero_b_s", 8'h80,  8'd0,   1'b1);

        // New operands pulsed during RUN must be ignored.
        wait_ready();
        bus.a = 8'd13; bus.b = 8'd11; bus.signed_mode = 1'b0; bus.start = 1'b1;
        sb_q.push_back(model(8'd13, 8'd11, 1'b0));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 8'd99; bus.b = 8'd77; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("midrun", cycles);
        exp = sb_q.pop_front();
        check("midrun_product", 32'(bus.product), 32'(exp));
        count_dones(12, cnt);
        check("midrun_no_2nd_done", 32'(cnt), 32'd0);
        check("midrun_product_hold", 32'(bus.product), 32'(exp));

        // start held high across two operations: accepted only when ready.
        wait_ready();
        bus.a = 8'd7; bus.b = 8'd1; bus.signed_mode = 1'b0; bus.start = 1'b1;
        sb_q.push_back(model(8'd7, 8'd1, 1'b0));
        sb_q.push_back(model(8'd7, 8'd1, 1'b0));
        pat[0] = 3'b010; pat[1] = 3'b001; pat[2] = 3'b100; pat[3] = 3'b010; pat[4] = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_flags_%0d", i), 32'({bus.ready, bus.busy, bus.done}),
                  32'(pat[i]));
            if (pat[i] == 3'b001) begin
                exp = sb_q.pop_front();
                check($sformatf("hold_product_%0d", i), 32'(bus.product), 32'(exp));
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        check("hold_idle", 32'({bus.ready, bus.busy, bus.done}), 32'(3'b100));
        check("hold_queue_empty", 32'(sb_q.size()), 32'd0);

        // Reset pulse during the third RUN cycle abandons the operation.
        wait_ready();
        bus.a = 8'd13; bus.b = 8'd11; bus.signed_mode = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_product", 32'(bus.product), 32'd0);
        check("midrst_flags", 32'({bus.ready, bus.busy, bus.done}), 32'(3'b100));
        @(negedge clk);
        reset_n = 1'b1;
        count_dones(10, cnt);
        check("midrst_no_done", 32'(cnt), 32'd0);
        run_op("u9x9", 8'd9, 8'd9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
